// File: rtl/o_sync_lock_pkg.sv
// o_sync_lock_pkg: state encodings, default scope timing, tolerance helper.
package o_sync_lock_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    SEARCH = 2'd2,
    LOCK   = 2'd3
  } state_t;
  localparam int   DEF_H_TOTAL = 800;
  localparam int   DEF_V_TOTAL = 417;
  localparam logic DEF_HS_POL  = 1'b0;
  localparam logic DEF_VS_POL  = 1'b0;
  function automatic logic in_tol(input int v, input int nom, input int tol);
    return v >= nom - tol && v <= nom + tol;
  endfunction
endpackage

// File: rtl/o_sync_lock_sync_edge_detect.sv
// o_sync_lock_sync_edge_detect: one-cycle pulse when a sync input enters its asserted level.
module o_sync_lock_sync_edge_detect #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic pulse
);
  logic prev;
  // prev resets to the asserted level so a sync already asserted at reset is not an edge
  always_ff @(posedge clk) prev <= rst ? POL : lvl;
  assign pulse = (lvl == POL) && (prev != POL);
endmodule

// File: rtl/o_sync_lock.sv
// o_sync_lock: measures scope HS/VS timing, locks after consistent frames and gates capture ENABLE.
module o_sync_lock
  import o_sync_lock_pkg::*;
#(
  parameter int   H_TOTAL     = DEF_H_TOTAL,
  parameter int   V_TOTAL     = DEF_V_TOTAL,
  parameter int   H_TOL       = 4,
  parameter int   V_TOL       = 2,
  parameter int   LOCK_FRAMES = 4,
  parameter int   LOSS_FRAMES = 2,
  parameter logic HS_POL      = DEF_HS_POL,
  parameter logic VS_POL      = DEF_VS_POL
) (
  input  logic        O_CLK,
  input  logic        RESET,
  input  logic        O_HS,
  input  logic        O_VS,
  input  logic        ARM,
  output logic        ENABLE,
  output logic        LOCKED,
  output logic [10:0] LINE_LEN,
  output logic [9:0]  FRAME_LINES,
  output logic [1:0]  STATE,
  output logic [7:0]  ERR_COUNT
);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
  localparam logic [7:0] LOSS_N = 8'(LOSS_FRAMES);
  state_t      st, st_n;
  logic        hs_e, vs_e, run, line_bad, frame_good, tmo, judge, fbad;
  logic [10:0] lclk, lclk_n;
  logic [9:0]  lcnt, lcnt_n;
  logic [7:0]  good, bad;
  o_sync_lock_sync_edge_detect #(.POL(HS_POL)) hs_det (
    .clk(O_CLK), .rst(RESET), .lvl(O_HS), .pulse(hs_e)
  );
  o_sync_lock_sync_edge_detect #(.POL(VS_POL)) vs_det (
    .clk(O_CLK), .rst(RESET), .lvl(O_VS), .pulse(vs_e)
  );
  // lclk_n/lcnt_n include the current cycle and a coincident HS edge, so they are the closing values
  always_comb begin
    run        = ARM && st != IDLE;
    lclk_n     = (lclk == 11'h7ff) ? lclk : lclk + 11'd1;
    lcnt_n     = (hs_e && lcnt != 10'h3ff) ? lcnt + 10'd1 : lcnt;
    line_bad   = hs_e && !in_tol(int'(lclk_n), H_TOTAL, H_TOL);
    frame_good = in_tol(int'(lcnt_n), V_TOTAL, V_TOL) && !fbad && !line_bad;
    tmo        = (!hs_e && int'(lclk_n) >= 2 * H_TOTAL) || int'(lcnt_n) >= 2 * V_TOTAL;
    judge      = vs_e && !tmo;
  end
  always_ff @(posedge O_CLK) begin
    if (RESET) begin
      lclk        <= '0;
      lcnt        <= '0;
      fbad        <= 1'b0;
      LINE_LEN    <= '0;
      FRAME_LINES <= '0;
    end else if (!run) begin
      lclk <= '0;
      lcnt <= '0;
      fbad <= 1'b0;
    end else begin
      lclk <= hs_e ? '0 : lclk_n;
      lcnt <= vs_e ? '0 : lcnt_n;
      fbad <= vs_e ? 1'b0 : (fbad || line_bad);
      if (hs_e) LINE_LEN <= lclk_n;
      if (vs_e) FRAME_LINES <= lcnt_n;
    end
  end
  always_ff @(posedge O_CLK) st <= RESET ? IDLE : st_n;
  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:    st_n = PRIME;
      PRIME:   st_n = vs_e ? SEARCH : PRIME;
      SEARCH:  st_n = (judge && frame_good && good + 8'd1 >= LOCK_N) ? LOCK : SEARCH;
      LOCK:    st_n = (tmo || (judge && !frame_good && bad + 8'd1 >= LOSS_N)) ? SEARCH : LOCK;
      default: st_n = IDLE;
    endcase
    if (!ARM) st_n = IDLE;
  end
  // good/bad only run while staying in their own state, so every exit leaves them cleared
  always_ff @(posedge O_CLK) begin
    if (RESET) begin
      good      <= '0;
      bad       <= '0;
      ERR_COUNT <= '0;
    end else begin
      good <= (st != SEARCH || st_n != SEARCH || tmo || (judge && !frame_good)) ? '0 :
              judge ? good + 8'd1 : good;
      bad  <= (st != LOCK || st_n != LOCK || (judge && frame_good)) ? '0 :
              judge ? bad + 8'd1 : bad;
      if (st == LOCK && judge && !frame_good && ERR_COUNT != 8'hff) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end
  always_comb begin
    STATE  = st;
    ENABLE = st == LOCK;
    LOCKED = st == LOCK;
  end
endmodule

// File: tb/tb_o_sync_lock.sv
// tb_o_sync_lock: table of frames with expected post-VS outputs, checked through a due-cycle scoreboard.
module tb_o_sync_lock;
  typedef struct {int due; int st; int en; int fl; int ll; int ec;} exp_t;
  typedef struct {int lines; int hlen; bit coinc; int st; int en; int fl; int ll; int ec;} row_t;
  logic        clk = 1'b0, rst = 1'b1, arm = 1'b0, hs = 1'b1, vs = 1'b1;
  logic        enable, locked;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [1:0]  state;
  logic [7:0]  err_count;
  int          cyc = 0, checks = 0, errors = 0, last_hs = 0;
  exp_t        sb[$];
  exp_t        e;
  row_t        rows[$];
  o_sync_lock #(
    .H_TOTAL(40), .V_TOTAL(12), .H_TOL(4), .V_TOL(2),
    .LOCK_FRAMES(4), .LOSS_FRAMES(2), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .O_CLK(clk), .RESET(rst), .O_HS(hs), .O_VS(vs), .ARM(arm),
    .ENABLE(enable), .LOCKED(locked), .LINE_LEN(line_len),
    .FRAME_LINES(frame_lines), .STATE(state), .ERR_COUNT(err_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void cmp(input string nm, input int act, input int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endfunction
  always @(negedge clk)
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      cmp("STATE", int'(state), e.st);
      cmp("ENABLE", int'(enable), e.en);
      cmp("LOCKED", int'(locked), e.en);
      cmp("FRAME_LINES", int'(frame_lines), e.fl);
      cmp("LINE_LEN", int'(line_len), e.ll);
      cmp("ERR_COUNT", int'(err_count), e.ec);
    end
  task automatic push(input int due, input int st, input int en, input int fl, input int ll, input int ec);
    exp_t x = '{due, st, en, fl, ll, ec};
    sb.push_back(x);
  endtask
  task automatic add(input int lines, input int hlen, input bit coinc,
                     input int st, input int en, input int fl, input int ll, input int ec);
    row_t r = '{lines, hlen, coinc, st, en, fl, ll, ec};
    rows.push_back(r);
  endtask
  task automatic tick(input logic h, input logic v);
    @(posedge clk);
    #1;
    hs = h;
    vs = v;
  endtask
  // VS asserts at pixel voff of line 0 (pixel 0 = coincident with HS); outputs checked 1 cycle later
  task automatic frame(input row_t r);
    int voff = r.coinc ? 0 : 7;
    for (int l = 0; l < r.lines; l++)
      for (int p = 0; p < r.hlen; p++) begin
        tick(p >= 4, !((l == 0 && p >= voff) || l == 1));
        if (p == 0) last_hs = cyc;
        if (l == 0 && p == voff) push(cyc + 1, r.st, r.en, r.fl, r.ll, r.ec);
      end
  endtask
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) frame(rows[i]);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    add(12, 40, 0, 2, 0, -1, -1, 0);
    repeat (3) add(12, 40, 0, 2, 0, 12, 40, 0);
    add(12, 40, 0, 3, 1, 12, 40, 0);
    add(15, 40, 0, 3, 1, 12, 40, 0);
    add(12, 40, 0, 3, 1, 15, 40, 1);
    add(12, 40, 0, 3, 1, 12, 40, 1);
    add(15, 40, 0, 3, 1, 12, 40, 1);
    add(15, 40, 0, 3, 1, 15, 40, 2);
    add(12, 40, 0, 2, 0, 15, 40, 3);
    repeat (3) add(12, 40, 1, 2, 0, 12, 40, 3);
    add(12, 40, 1, 3, 1, 12, 40, 3);
    add(12, 45, 0, 2, 0, -1, -1, 3);
    repeat (5) add(12, 45, 0, 2, 0, 12, 45, 3);
    add(14, 44, 0, 2, 0, 12, 45, 3);
    repeat (3) add(14, 44, 0, 2, 0, 14, 44, 3);
    add(14, 44, 0, 3, 1, 14, 44, 3);
    add(12, 40, 0, 2, 0, -1, -1, 3);
    repeat (3) add(12, 40, 0, 2, 0, 12, 40, 3);
    add(12, 40, 0, 3, 1, 12, 40, 3);
    repeat (3) tick(1, 1);
    rst = 1'b0;
    push(cyc + 1, 0, 0, 0, 0, 0);
    tick(1, 1);
    arm = 1'b1;
    push(cyc + 1, 1, 0, -1, -1, 0);
    run_rows(0, 14);
    push(last_hs + 80, 3, 1, -1, -1, 3);
    push(last_hs + 81, 2, 0, -1, -1, 3);
    repeat (50) tick(1, 1);
    run_rows(15, 25);
    tick(1, 1);
    arm = 1'b0;
    push(cyc, 3, 1, -1, -1, 3);
    push(cyc + 1, 0, 0, -1, -1, 3);
    repeat (4) tick(1, 1);
    push(cyc, 0, 0, -1, -1, 3);
    tick(1, 1);
    arm = 1'b1;
    push(cyc + 1, 1, 0, -1, -1, 3);
    run_rows(26, 30);
    tick(1, 1);
    rst = 1'b1;
    push(cyc, 3, 1, -1, -1, 3);
    push(cyc + 1, 0, 0, 0, 0, 0);
    tick(1, 1);
    rst = 1'b0;
    repeat (3) tick(1, 1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations still pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
